// File: rtl/mmu_seq_ctrl.sv
// Loop sequencer for one matrix-multiply pass: walks (row, col) over an R x C
// command, then waits a fixed drain before pulsing done.

module mmu_seq_loop_ctr #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] end_val,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   assign wrap = en && (value == end_val);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         value <= '0;
      end else if (en) begin
         value <= wrap ? '0 : value + ONE;
      end
   end

endmodule

module mmu_seq_ctrl #(
   parameter int unsigned COUNTER_WIDTH = 6,
   parameter int unsigned DRAIN_CYCLES  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [COUNTER_WIDTH-1:0] cmd_rows,
   input  logic [COUNTER_WIDTH-1:0] cmd_cols,
   input  logic                     stall,
   output logic                     issue_valid,
   output logic [COUNTER_WIDTH-1:0] issue_row,
   output logic [COUNTER_WIDTH-1:0] issue_col,
   output logic                     issue_last,
   output logic                     busy,
   output logic                     done
);

   // A zero-length drain still needs a 1-bit counter to keep the RTL legal.
   localparam int unsigned DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
   localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_LAST);
   localparam logic [DW-1:0] DRAIN_ONE = DW'(1);
   localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   state;
   logic [COUNTER_WIDTH-1:0] rows_q;
   logic [COUNTER_WIDTH-1:0] cols_q;
   logic [DW-1:0]            drain_cnt;
   logic                     accept;
   logic                     beat;
   logic                     col_wrap;
   logic                     row_wrap;
   logic                     zero_size;

   assign accept    = cmd_valid && cmd_ready;
   assign beat      = (state == S_RUN) && !stall;
   assign zero_size = (cmd_rows == '0) || (cmd_cols == '0);

   mmu_seq_loop_ctr #(.WIDTH(COUNTER_WIDTH)) u_col_ctr (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .en      (beat),
      .end_val (cols_q - ONE),
      .value   (issue_col),
      .wrap    (col_wrap)
   );

   // The row wraps only on the final beat, so its wrap event marks the end of RUN.
   mmu_seq_loop_ctr #(.WIDTH(COUNTER_WIDTH)) u_row_ctr (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .en      (beat && col_wrap),
      .end_val (rows_q - ONE),
      .value   (issue_row),
      .wrap    (row_wrap)
   );

   assign issue_valid = beat;
   assign issue_last  = (state == S_RUN) &&
                        (issue_row == rows_q - ONE) &&
                        (issue_col == cols_q - ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q <= '0;
         cols_q <= '0;
      end else if (accept) begin
         rows_q <= cmd_rows;
         cols_q <= cmd_cols;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (zero_size) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (row_wrap) begin
                  if (DRAIN_CYCLES != 0) begin
                     state     <= S_DRAIN;
                     drain_cnt <= '0;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRAIN_END) begin
                  state     <= S_DONE;
                  drain_cnt <= '0;
                  done      <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DRAIN_ONE;
               end
            end
            default: begin
               state     <= S_IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
